// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch-path constants and the {pc, instr} fetch word layout.
// Also consumed by the fetch controller (RESET_PC, ECALL_VECTOR).
package instr_fetch_queue_pkg;

    localparam int FETCH_WORD_W = 64;
    localparam int PC_W         = 32;
    localparam int INSTR_W      = 32;

    localparam int PC_MSB    = 63;
    localparam int PC_LSB    = 32;
    localparam int INSTR_MSB = 31;
    localparam int INSTR_LSB = 0;

    localparam logic [PC_W-1:0] RESET_PC     = 32'd0;
    localparam logic [PC_W-1:0] ECALL_VECTOR = 32'd200;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_word_t;

    function automatic fetch_word_t unpack_fetch_word(input logic [FETCH_WORD_W-1:0] raw);
        fetch_word_t w;
        w.pc    = raw[PC_MSB:PC_LSB];
        w.instr = raw[INSTR_MSB:INSTR_LSB];
        return w;
    endfunction

endpackage

// File: rtl/instr_fetch_queue_sync_fifo_ram.sv
// Purpose: DEPTH x WIDTH register array, one write port, one combinational read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the owner gates wr_en.
module sync_fifo_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset; occupancy lives in the owner.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Purpose: in-order {pc, instr} buffer between the I-cache fetch controller and issue.
// Latency: 1 cycle push-to-head, first-word-fall-through head, no empty bypass.
// Backpressure: stop_fetch at DEPTH-AFULL_MARGIN; pushes while full without a pop are dropped and flag overflow.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 2,
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_valid,
    input  logic [FETCH_WORD_W-1:0] fetch_instr_pc,
    input  logic                    flush,
    input  logic                    deq_ready,
    output logic                    deq_valid,
    output logic [PC_W-1:0]         deq_pc,
    output logic [INSTR_W-1:0]      deq_instr,
    output logic [CW-1:0]           count,
    output logic                    full,
    output logic                    stop_fetch,
    output logic                    overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_LEVEL = CW'(DEPTH - AFULL_MARGIN);

    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [CW-1:0]           count_q;
    logic                    overflow_q;
    logic                    push;
    logic                    pop;
    logic                    drop;
    logic [FETCH_WORD_W-1:0] head_raw;
    fetch_word_t             head_word;

    assign deq_valid  = (count_q != '0);
    assign full       = (count_q == FULL_COUNT);
    assign stop_fetch = (count_q >= AFULL_LEVEL);
    assign count      = count_q;
    assign overflow   = overflow_q;

    // A pop frees the slot in the same cycle, so a full queue still accepts a beat.
    assign pop  = deq_ready & deq_valid;
    assign push = fetch_valid & ~flush & (~full | pop);
    assign drop = fetch_valid & ~flush & full & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (flush) begin
            rd_ptr  <= wr_ptr;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    sync_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (FETCH_WORD_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (fetch_instr_pc),
        .rd_addr (rd_ptr),
        .rd_data (head_raw)
    );

    assign head_word = unpack_fetch_word(head_raw);

    // Stale array contents must not leak out while empty.
    assign deq_pc    = deq_valid ? head_word.pc    : '0;
    assign deq_instr = deq_valid ? head_word.instr : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed-vector bench for instr_fetch_queue (DEPTH=8, AFULL_MARGIN=2).
module tb_instr_fetch_queue;

    logic        clk;
    logic        rst;
    logic        fetch_valid;
    logic [63:0] fetch_instr_pc;
    logic        flush;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic [3:0]  count;
    logic        full;
    logic        stop_fetch;
    logic        overflow;

    int vec_cnt;
    int err_cnt;

    instr_fetch_queue #(
        .DEPTH        (8),
        .AFULL_MARGIN (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_valid    (fetch_valid),
        .fetch_instr_pc (fetch_instr_pc),
        .flush          (flush),
        .deq_ready      (deq_ready),
        .deq_valid      (deq_valid),
        .deq_pc         (deq_pc),
        .deq_instr      (deq_instr),
        .count          (count),
        .full           (full),
        .stop_fetch     (stop_fetch),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given inputs held across the edge; outputs sampled 1 time unit after.
    task automatic tick(input logic fv, input logic [31:0] pc, input logic fl, input logic dr);
        fetch_valid    = fv;
        fetch_instr_pc = {pc, instr_of(pc)};
        flush          = fl;
        deq_ready      = dr;
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        deq_ready   = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_cnt"}, 64'(count), 64'd0);
        chk({tag, "_vld"}, 64'(deq_valid), 64'd0);
        chk({tag, "_pc"}, 64'(deq_pc), 64'd0);
        chk({tag, "_ins"}, 64'(deq_instr), 64'd0);
        chk({tag, "_full"}, 64'(full), 64'd0);
        chk({tag, "_stop"}, 64'(stop_fetch), 64'd0);
    endtask

    initial begin
        vec_cnt        = 0;
        err_cnt        = 0;
        rst            = 1'b1;
        fetch_valid    = 1'b0;
        fetch_instr_pc = '0;
        flush          = 1'b0;
        deq_ready      = 1'b0;

        // Reset
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        rst = 1'b0;
        chk_idle("rst");
        chk("rst_ovf", 64'(overflow), 64'd0);

        // Three pushes, then drain in order
        tick(1, 32'h0, 0, 0);
        tick(1, 32'h4, 0, 0);
        tick(1, 32'h8, 0, 0);
        chk("b_cnt", 64'(count), 64'd3);
        chk("b_vld", 64'(deq_valid), 64'd1);
        chk("b_pc0", 64'(deq_pc), 64'h0);
        chk("b_ins0", 64'(deq_instr), 64'(instr_of(32'h0)));
        tick(0, 0, 0, 1);
        chk("b_pc1", 64'(deq_pc), 64'h4);
        tick(0, 0, 0, 1);
        chk("b_pc2", 64'(deq_pc), 64'h8);
        chk("b_ins2", 64'(deq_instr), 64'(instr_of(32'h8)));
        tick(0, 0, 0, 1);
        chk("b_cnt_end", 64'(count), 64'd0);
        chk("b_vld_end", 64'(deq_valid), 64'd0);

        // Push into empty with deq_ready: no bypass
        tick(1, 32'h500, 0, 1);
        chk("nb_cnt", 64'(count), 64'd1);
        chk("nb_pc", 64'(deq_pc), 64'h500);
        tick(0, 0, 0, 1);
        chk("nb_cnt_end", 64'(count), 64'd0);

        // Streaming across pointer wrap
        tick(1, 32'h4000, 0, 0);
        for (int k = 0; k < 20; k++) begin
            chk("st_pc", 64'(deq_pc), 64'(32'h4000 + 32'(4 * k)));
            tick(1, 32'h4000 + 32'(4 * (k + 1)), 0, 1);
            chk("st_cnt", 64'(count), 64'd1);
        end
        chk("st_ovf", 64'(overflow), 64'd0);
        tick(0, 0, 0, 1);
        chk("st_cnt_end", 64'(count), 64'd0);

        // Almost-full, full, overflow
        for (int i = 0; i < 8; i++) begin
            tick(1, 32'h1000 + 32'(4 * i), 0, 0);
            if (i == 4) chk("af_stop5", 64'(stop_fetch), 64'd0);
            if (i == 5) begin
                chk("af_stop6", 64'(stop_fetch), 64'd1);
                chk("af_full6", 64'(full), 64'd0);
            end
        end
        chk("f_full", 64'(full), 64'd1);
        chk("f_cnt", 64'(count), 64'd8);
        chk("f_ovf0", 64'(overflow), 64'd0);
        tick(1, 32'h2000, 0, 0);
        chk("ov_ovf", 64'(overflow), 64'd1);
        chk("ov_cnt", 64'(count), 64'd8);
        chk("ov_pc", 64'(deq_pc), 64'h1000);

        // Full with simultaneous push and pop
        tick(1, 32'h40, 0, 1);
        chk("fp_cnt", 64'(count), 64'd8);
        chk("fp_pc", 64'(deq_pc), 64'h1004);
        for (int i = 0; i < 8; i++) begin
            chk("fp_drain_pc", 64'(deq_pc), (i < 7) ? 64'(32'h1004 + 32'(4 * i)) : 64'h40);
            tick(0, 0, 0, 1);
        end
        chk("fp_cnt_end", 64'(count), 64'd0);
        chk("fp_ovf", 64'(overflow), 64'd1);

        // Flush with a wrong-path beat
        for (int i = 0; i < 5; i++) tick(1, 32'h3000 + 32'(4 * i), 0, 0);
        chk("fl_cnt5", 64'(count), 64'd5);
        tick(1, 32'h100, 1, 0);
        chk("fl_cnt", 64'(count), 64'd0);
        chk("fl_vld", 64'(deq_valid), 64'd0);
        chk("fl_ovf", 64'(overflow), 64'd1);
        tick(1, 32'h200, 0, 0);
        chk("fl_pc", 64'(deq_pc), 64'h200);
        chk("fl_cnt1", 64'(count), 64'd1);
        tick(0, 0, 0, 1);

        // Reset mid-operation with entries and overflow set
        for (int i = 0; i < 4; i++) tick(1, 32'h7000 + 32'(4 * i), 0, 0);
        chk("mr_cnt4", 64'(count), 64'd4);
        rst = 1'b1;
        tick(1, 32'h7777, 0, 1);
        rst = 1'b0;
        chk_idle("mr");
        chk("mr_ovf", 64'(overflow), 64'd0);
        tick(1, 32'h600, 0, 0);
        chk("mr_cnt1", 64'(count), 64'd1);
        chk("mr_pc", 64'(deq_pc), 64'h600);
        chk("mr_ins", 64'(deq_instr), 64'(instr_of(32'h600)));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Instruction buffer directly downstream of the instruction-cache fetch controller.
- Captures each completed fetch beat as a 64-bit {pc, instr} word and holds it in order for the scoreboard issue/decode stage.
- Sends back-pressure (stop_fetch) to the fetch controller and flushes all wrong-path entries when a jump is accepted.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 4.
- AFULL_MARGIN, 2, stop_fetch asserts when count >= DEPTH - AFULL_MARGIN; range 1..DEPTH-1.
- CW, $clog2(DEPTH)+1, width of the count output (derived, not overridable).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_valid  in  1  completed fetch beat (rvalid & rlast at the fetch controller).
- fetch_instr_pc  in  64  [63:32] = pc, [31:0] = instruction.
- flush  in  1  jump accepted (j_accept); discards all queued entries.
- deq_ready  in  1  issue stage consumes the head entry this cycle.
- deq_valid  out  1  head entry is valid.
- deq_pc  out  32  pc of the head entry.
- deq_instr  out  32  instruction of the head entry.
- count  out  CW  number of occupied entries.
- full  out  1  count == DEPTH.
- stop_fetch  out  1  almost-full back-pressure to the fetch controller.
- overflow  out  1  sticky flag: a push was dropped because the queue was full.

Behaviour:
- Storage: circular array of DEPTH x 64 bits, with log2(DEPTH)-bit write and read pointers that wrap naturally modulo DEPTH. The occupancy counter is CW bits.
- Reset (rst=1 at a clk edge): pointers = 0, count = 0, overflow = 0. Consequently deq_valid = 0, full = 0, stop_fetch = 0. Array contents are don't-care and are not reset.
- Reset mid-operation discards all entries. Reset has priority over every other input.
- Head outputs are first-word-fall-through:
  - deq_valid = (count != 0).
  - deq_pc and deq_instr are read combinationally from mem[rd_ptr].
  - When deq_valid = 0, deq_pc and deq_instr are 0.
- Push condition: fetch_valid & !flush & (!full | pop).
  - Writes mem[wr_ptr] and increments wr_ptr.
  - The entry appears on deq_* one cycle after the push edge (1-cycle latency).
- Pop condition: deq_ready & deq_valid. Increments rd_ptr.
- deq_ready while empty has no effect. This includes the cycle in which a push into an empty queue occurs: no bypass, the entry pops at the earliest on the next cycle.
- Count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Full and pop in the same cycle: the push is accepted and count stays DEPTH.
- Full and fetch_valid without pop: the push is dropped and overflow is set. overflow is cleared only by rst.
- Flush has priority over push and pop:
  - Next cycle: rd_ptr = wr_ptr, count = 0.
  - A same-cycle fetch_valid is discarded, since it is a wrong-path beat.
  - overflow is unaffected.
- stop_fetch = (count >= DEPTH - AFULL_MARGIN). It is registered-equivalent, i.e. derived from the count register with no combinational path from any input.
  - The margin absorbs fetch beats already in flight after stop_fetch rises.
- full and stop_fetch are derived from count only.
- No combinational path exists from fetch_valid, flush or deq_ready to any output.

Decomposition:
- A shared package holds:
  - FETCH_WORD_W = 64, PC_W = 32, INSTR_W = 32.
  - Field-slice constants for fetch_instr_pc ([63:32] pc, [31:0] instr).
  - RESET_PC = 0 and ECALL_VECTOR = 200, shared with the fetch controller.
- One natural sub-module: sync_fifo_ram, a DEPTH x width register array with one write port and one combinational read port. Pointer, count and flush control stay in instr_fetch_queue.

Test Plan:
- Reset then 3 pushes with pc 0x0, 0x4, 0x8 and deq_ready = 0 -> count = 3, deq_valid = 1, deq_pc = 0x0; then deq_ready = 1 for 3 cycles -> deq_pc sequence 0x0, 0x4, 0x8, after which count = 0 and deq_valid = 0.
- With DEPTH = 8, AFULL_MARGIN = 2, push 6 entries -> stop_fetch rises the cycle after the 6th push. Push 2 more -> full = 1. A 9th push -> dropped, overflow = 1, count = 8, head unchanged.
- Full queue, fetch_valid and deq_ready in the same cycle with pc 0x40 -> count stays 8, head advances one entry, 0x40 is the last entry popped after 8 further pops.
- 5 entries queued, flush together with fetch_valid (pc 0x100) -> next cycle count = 0, deq_valid = 0. A following push of pc 0x200 -> deq_pc = 0x200.
- Push/pop streaming for 20 cycles with pc incrementing by 4 -> pointer wrap-around preserves order, count steady at 1, no overflow.
- rst asserted with 4 entries and overflow = 1 -> next cycle all outputs are 0, and a subsequent push behaves as it does after a fresh reset.
